// File: rtl/tmds_ddr_serializer.sv
// ============================================================================
// Module      : tmds_ddr_serializer
// Description : 10:2 TMDS serializer. It emits one symbol per channel every five
//               clk_shift cycles as 2-bit DDR slices, and inserts an idle symbol on underflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmds_ddr_serializer #(
  parameter logic [9:0] CLK_PATTERN = 10'b0000011111,
  parameter logic [9:0] IDLE_SYMBOL = 10'b1101010100
) (
  input  logic        clk_shift,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_red,
  input  logic [9:0]  in_green,
  input  logic [9:0]  in_blue,
  output logic [1:0]  out_clock,
  output logic [1:0]  out_red,
  output logic [1:0]  out_green,
  output logic [1:0]  out_blue,
  output logic        underflow,
  output logic [15:0] underflow_count
);

  logic [2:0]  phase_q, phase_d;
  logic [9:0]  clk_sr_q, clk_sr_d;
  logic [9:0]  red_sr_q, red_sr_d;
  logic [9:0]  green_sr_q, green_sr_d;
  logic [9:0]  blue_sr_q, blue_sr_d;
  logic        ready_q, ready_d;
  logic        underflow_q, underflow_d;
  logic [15:0] underflow_count_q, underflow_count_d;
  logic        load;

  always_comb begin
    load              = (phase_q >= 3'd4);
    phase_d           = load ? 3'd0 : phase_q + 3'd1;
    ready_d           = (phase_d == 3'd4);
    underflow_d       = load && !in_valid;
    underflow_count_d = underflow_count_q;
    if (underflow_d && (underflow_count_q != 16'hFFFF))
      underflow_count_d = underflow_count_q + 16'd1;

    // All four channels reload on the same edge so they stay symbol-aligned.
    if (load) begin
      clk_sr_d = CLK_PATTERN;
      if (in_valid) begin
        red_sr_d   = in_red;
        green_sr_d = in_green;
        blue_sr_d  = in_blue;
      end else begin
        red_sr_d   = IDLE_SYMBOL;
        green_sr_d = IDLE_SYMBOL;
        blue_sr_d  = IDLE_SYMBOL;
      end
    end else begin
      clk_sr_d   = {2'b00, clk_sr_q[9:2]};
      red_sr_d   = {2'b00, red_sr_q[9:2]};
      green_sr_d = {2'b00, green_sr_q[9:2]};
      blue_sr_d  = {2'b00, blue_sr_q[9:2]};
    end
  end

  always_ff @(posedge clk_shift or negedge rst_n) begin
    if (!rst_n) begin
      phase_q           <= 3'd0;
      clk_sr_q          <= CLK_PATTERN;
      red_sr_q          <= IDLE_SYMBOL;
      green_sr_q        <= IDLE_SYMBOL;
      blue_sr_q         <= IDLE_SYMBOL;
      ready_q           <= 1'b0;
      underflow_q       <= 1'b0;
      underflow_count_q <= 16'd0;
    end else begin
      phase_q           <= phase_d;
      clk_sr_q          <= clk_sr_d;
      red_sr_q          <= red_sr_d;
      green_sr_q        <= green_sr_d;
      blue_sr_q         <= blue_sr_d;
      ready_q           <= ready_d;
      underflow_q       <= underflow_d;
      underflow_count_q <= underflow_count_d;
    end
  end

  assign in_ready        = ready_q;
  assign out_clock       = clk_sr_q[1:0];
  assign out_red         = red_sr_q[1:0];
  assign out_green       = green_sr_q[1:0];
  assign out_blue        = blue_sr_q[1:0];
  assign underflow       = underflow_q;
  assign underflow_count = underflow_count_q;

endmodule

`default_nettype wire

// File: tb/tb_tmds_ddr_serializer.sv
// ============================================================================
// Module      : tb_tmds_ddr_serializer
// Description : Self-checking bench; a slot-level model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmds_ddr_serializer;

  localparam logic [9:0] CLKP = 10'b0000011111;
  localparam logic [9:0] IDLE = 10'b1101010100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [9:0]  in_red = '0, in_green = '0, in_blue = '0;
  logic        in_ready, underflow;
  logic [1:0]  out_clock, out_red, out_green, out_blue;
  logic [15:0] underflow_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  tmds_ddr_serializer dut (
    .clk_shift       (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_red          (in_red),
    .in_green        (in_green),
    .in_blue         (in_blue),
    .out_clock       (out_clock),
    .out_red         (out_red),
    .out_green       (out_green),
    .out_blue        (out_blue),
    .underflow       (underflow),
    .underflow_count (underflow_count)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] slice(input logic [9:0] sym, input int k);
    logic [9:0] v;
    v = sym >> (2 * k);
    return v[1:0];
  endfunction

  // Model: cycles since reset release, grouped in 5-cycle symbol slots.
  int t;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) t <= 0;
    else        t <= t + 1;

  logic [9:0]  m_r[64], m_g[64], m_b[64];
  logic        m_uf[64];
  logic [15:0] m_cnt[64];

  always @(negedge clk) begin
    int s, k;
    if (!rst_n) begin
      m_r[0] = IDLE; m_g[0] = IDLE; m_b[0] = IDLE;
      m_uf[0] = 1'b0; m_cnt[0] = 16'd0;
      chk("rst_red",   {14'd0, out_red},   16'd0);
      chk("rst_clock", {14'd0, out_clock}, 16'd3);
      chk("rst_ready", {15'd0, in_ready},  16'd0);
      chk("rst_count", underflow_count,    16'd0);
    end else begin
      s = t / 5;
      k = t % 5;
      chk("clock", {14'd0, out_clock}, {14'd0, slice(CLKP, k)});
      chk("red",   {14'd0, out_red},   {14'd0, slice(m_r[s % 64], k)});
      chk("green", {14'd0, out_green}, {14'd0, slice(m_g[s % 64], k)});
      chk("blue",  {14'd0, out_blue},  {14'd0, slice(m_b[s % 64], k)});
      chk("ready", {15'd0, in_ready},  {15'd0, (k == 4)});
      chk("underflow", {15'd0, underflow}, {15'd0, (k == 0) && m_uf[s % 64]});
      chk("count", underflow_count, m_cnt[s % 64]);
      if (k == 4) begin
        if (in_valid) begin
          m_r[(s + 1) % 64] = in_red;
          m_g[(s + 1) % 64] = in_green;
          m_b[(s + 1) % 64] = in_blue;
          m_uf[(s + 1) % 64] = 1'b0;
          m_cnt[(s + 1) % 64] = m_cnt[s % 64];
        end else begin
          m_r[(s + 1) % 64] = IDLE;
          m_g[(s + 1) % 64] = IDLE;
          m_b[(s + 1) % 64] = IDLE;
          m_uf[(s + 1) % 64] = 1'b1;
          m_cnt[(s + 1) % 64] = (m_cnt[s % 64] == 16'hFFFF) ? 16'hFFFF : m_cnt[s % 64] + 16'd1;
        end
      end
    end
  end

  // Idle stream after release, pinned against hand-derived slices.
  task automatic idle_seq();
    logic [1:0] red_lit[5];
    logic [1:0] clk_lit[5];
    red_lit = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
    clk_lit = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("lit_idle_red",   {14'd0, out_red},   {14'd0, red_lit[i % 5]});
      chk("lit_idle_clock", {14'd0, out_clock}, {14'd0, clk_lit[i % 5]});
    end
    @(negedge clk);
    chk("lit_count_4", underflow_count, 16'd4);
  endtask

  initial begin
    int rdy, ufs, s;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle_seq();

    // Constant data stream.
    @(posedge clk); #1;
    in_valid = 1'b1; in_red = 10'h3FF; in_green = 10'h000; in_blue = 10'h2AA;
    repeat (6) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("lit_const_red",   {14'd0, out_red},   16'd3);
      chk("lit_const_green", {14'd0, out_green}, 16'd0);
      chk("lit_const_blue",  {14'd0, out_blue},  16'd2);
      chk("lit_const_uf",    {15'd0, underflow}, 16'd0);
    end

    // Random valid/data, including changes outside the load phase.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_red   = 10'($urandom);
      in_green = 10'($urandom);
      in_blue  = 10'($urandom);
    end

    // Continuous valid with an incrementing red value.
    rdy = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (t % 5 == 0) in_red = in_red + 10'd1;
      @(negedge clk);
      if (in_ready) rdy++;
    end
    chk("lit_accept_100", 16'(rdy), 16'd20);

    // A single dropped load slot.
    ufs = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      in_valid = !((t % 5 == 4) && (i >= 5) && (i < 10));
      if (t % 5 == 0) begin
        in_red = 10'($urandom); in_green = 10'($urandom); in_blue = 10'($urandom);
      end
      @(negedge clk);
      if (underflow) ufs++;
    end
    chk("lit_single_uf", 16'(ufs), 16'd1);

    // Reset in the middle of a data symbol.
    in_valid = 1'b1;
    for (int i = 0; i < 6 && (t % 5 != 2); i++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_red",   {14'd0, out_red},   16'd0);
    chk("lit_async_green", {14'd0, out_green}, 16'd0);
    chk("lit_async_blue",  {14'd0, out_blue},  16'd0);
    chk("lit_async_clock", {14'd0, out_clock}, 16'd3);
    chk("lit_async_uf",    {15'd0, underflow}, 16'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle_seq();

    // Saturation: preload the counter just below its ceiling.
    #1;
    s = t / 5;
    force dut.underflow_count_q = 16'hFFFE;
    m_cnt[s % 64] = 16'hFFFE;
    #1;
    release dut.underflow_count_q;
    repeat (15) @(negedge clk);
    chk("lit_saturate", underflow_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tmds_ddr_serializer.md
TMDS_DDR_SERIALIZER -- requirements
Module: tmds_ddr_serializer

Interface
REQ-001 The block SHALL have parameter CLK_PATTERN, default 10'b0000011111, meaning the TMDS clock-channel symbol.
REQ-002 The block SHALL have parameter IDLE_SYMBOL, default 10'b1101010100, meaning the control symbol (C1=0,C0=0) sent on all colour channels when no data is available.
REQ-003 The block SHALL have port clk_shift, input, 1 bit: the single clock, equal to 5x pixel clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a pixel symbol triple is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the triple is consumed this cycle if in_valid=1.
REQ-007 The block SHALL have ports in_red, in_green and in_blue, each input, 10 bits: TMDS-encoded symbols, bit0 transmitted first.
REQ-008 The block SHALL have ports out_clock, out_red, out_green and out_blue, each output, 2 bits: DDR slice for the downstream fake-differential stage, with [0] the first half-cycle.
REQ-009 The block SHALL have port underflow, output, 1 bit: one-cycle pulse when a symbol slot was filled with IDLE_SYMBOL.
REQ-010 The block SHALL have port underflow_count, output, 16 bits: saturating count of underflow events.

Function
REQ-011 The block SHALL keep a phase counter of 0..4 that increments every clk_shift cycle and wraps from 4 to 0.
REQ-012 in_ready SHALL be 1 exactly when phase==4, independent of in_valid.
REQ-013 The block SHALL hold one 10-bit shift register per channel (clock, red, green, blue).
REQ-014 The out_* ports SHALL be driven directly from bits [1:0] of the corresponding shift register, with no combinational logic on the output path.
REQ-015 At phases 0..3 each shift register SHALL shift right by 2 bits.
REQ-016 At phase 4 with in_valid=1, the colour shift registers SHALL load in_red, in_green and in_blue respectively.
REQ-017 At phase 4 with in_valid=0, all three colour shift registers SHALL load IDLE_SYMBOL, and underflow SHALL be 1 in the following cycle only.
REQ-018 The clock shift register SHALL load CLK_PATTERN at every phase 4, regardless of in_valid.
REQ-019 Latency: a triple accepted at cycle N SHALL appear as bits[1:0] at cycle N+1, then bits[3:2], [5:4], [7:6] and [9:8] at cycles N+2..N+5.
REQ-020 Throughput SHALL be exactly one triple per 5 cycles; in_valid=1 outside phase 4 SHALL have no effect.
REQ-021 No data SHALL be buffered beyond the shift registers; the upstream must hold its data until in_ready.
REQ-022 underflow_count SHALL increment on each underflow pulse and saturate at 16'hFFFF, with no wrap.
REQ-023 The colour and clock channels SHALL remain symbol-aligned at all times, with all four loaded on the same cycle.

Reset
REQ-024 On rst_n=0, the block SHALL immediately and asynchronously set phase=0.
REQ-025 On rst_n=0, the colour shift registers SHALL be set to IDLE_SYMBOL, so that out_red, out_green and out_blue = 2'b00.
REQ-026 On rst_n=0, the clock shift register SHALL be set to CLK_PATTERN, so that out_clock=2'b11.
REQ-027 On rst_n=0, in_ready SHALL be 0, underflow SHALL be 0, and underflow_count SHALL be 0.
REQ-028 After release, the first symbol period SHALL emit IDLE_SYMBOL and CLK_PATTERN in full, and the first in_ready SHALL occur on the 5th rising edge.
REQ-029 A reset asserted mid-symbol SHALL discard the partial symbol, and no truncated symbol SHALL be emitted after release.

Verification
REQ-030 Release reset with in_valid=0 -> out_red SHALL repeat 00,01,01,01,11 and out_clock SHALL repeat 11,11,01,00,00; underflow SHALL pulse once per 5 cycles; underflow_count SHALL be 4 after 20 cycles.
REQ-031 Hold in_valid=1 continuously with red=10'h3FF, green=10'h000, blue=10'h2AA -> out_red SHALL be 11 and out_blue 10 in every cycle, out_green SHALL be 00, and underflow SHALL be 0.
REQ-032 Hold in_valid=1 for 100 cycles with an incrementing red value -> exactly 20 acceptances SHALL occur, and the sequence SHALL be emitted in order with none skipped.
REQ-033 Drop in_valid only in a phase-4 cycle -> that slot SHALL carry IDLE_SYMBOL with a single underflow pulse, and the next accepted triple SHALL be serialized intact.
REQ-034 Assert rst_n=0 at phase 2 of a data symbol -> outputs SHALL be 00 (colour) and 11 (clock) within the same cycle, and behaviour after release SHALL be identical to REQ-030.
REQ-035 Force underflow_count to 16'hFFFE with underflows continuing -> the count SHALL reach 16'hFFFF and hold.
